// File: rtl/ctrl_trace_encoder_pkg.sv
// Shared opcode, control-word and statistics-class definitions for the control trace encoder.
package ctrl_trace_encoder_pkg;

    localparam logic [5:0] OP_R_TYPE  = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ILLEGAL = 6'h3F;

    // Bit order: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,BranchNE,BranchEQ,Jump,ALUOp[2:0]}
    localparam logic [11:0] CW_R_TYPE  = 12'h907;
    localparam logic [11:0] CW_ADDI    = 12'h500;
    localparam logic [11:0] CW_ORI     = 12'h502;
    localparam logic [11:0] CW_ANDI    = 12'h003;
    localparam logic [11:0] CW_LUI     = 12'h005;
    localparam logic [11:0] CW_LW      = 12'h780;
    localparam logic [11:0] CW_SW      = 12'h800;
    localparam logic [11:0] CW_DEFAULT = 12'h000;
    localparam logic [11:0] CW_BEQ     = 12'h014;
    localparam logic [11:0] CW_BNE     = 12'h024;
    localparam logic [11:0] CW_J       = 12'h00E;
    localparam logic [11:0] CW_JAL     = 12'h00C;

    typedef enum logic [2:0] {
        CLS_ALU = 3'd0,
        CLS_MEM = 3'd1,
        CLS_BR  = 3'd2,
        CLS_JMP = 3'd3,
        CLS_ILL = 3'd4
    } trace_class_e;

endpackage

// File: rtl/ctrl_trace_encoder_trace_fifo.sv
// Synchronous trace FIFO with extra-MSB pointers; reports entries dropped while full.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 39
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_pushData,
    input  logic         i_pop,
    output logic [W-1:0] o_headData,
    output logic         o_valid,
    output logic         o_full,
    output logic         o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  r_wrPtr;
    logic [AW:0]  r_rdPtr;
    logic [W-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_doPop;
    logic w_doPush;

    assign w_empty  = (r_wrPtr == r_rdPtr);
    assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_doPush = i_push && (!w_full || w_doPop);
    assign o_drop   = i_push && !w_doPush;

    assign o_valid    = !w_empty;
    assign o_full     = w_full;
    assign o_headData = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ctrl_trace_encoder.sv
// Re-encodes issued control bundles to opcodes, queues them for the debug port and keeps class statistics.
module ctrl_trace_encoder
    import ctrl_trace_encoder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [11:0]      ctrl_word,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             out_ready,
    input  logic             clr_stats,
    output logic             out_valid,
    output logic [5:0]       out_opcode,
    output logic             out_illegal,
    output logic [PC_W-1:0]  out_pc,
    output logic             fifo_full,
    output logic             overflow,
    output logic [CNT_W-1:0] cnt_alu,
    output logic [CNT_W-1:0] cnt_mem,
    output logic [CNT_W-1:0] cnt_br,
    output logic [CNT_W-1:0] cnt_jmp,
    output logic [CNT_W-1:0] cnt_ill
);

    localparam int FW = PC_W + 7;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic              r_capValid;
    logic [11:0]       r_capWord;
    logic [PC_W-1:0]   r_capPc;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_cntAlu;
    logic [CNT_W-1:0]  r_cntMem;
    logic [CNT_W-1:0]  r_cntBr;
    logic [CNT_W-1:0]  r_cntJmp;
    logic [CNT_W-1:0]  r_cntIll;

    logic [5:0]        w_opcode;
    logic              w_illegal;
    trace_class_e      w_class;
    logic [FW-1:0]     w_head;
    logic              w_drop;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_capValid <= 1'b0;
            r_capWord  <= '0;
            r_capPc    <= '0;
        end else begin
            r_capValid <= in_valid;
            if (in_valid) begin
                r_capWord <= ctrl_word;
                r_capPc   <= in_pc;
            end
        end
    end

    // The decoder's default bundle 0x000 aliases to SW and is deliberately not flagged.
    always_comb begin
        w_opcode  = OP_ILLEGAL;
        w_illegal = 1'b1;
        w_class   = CLS_ILL;
        case (r_capWord)
            CW_R_TYPE:          begin w_opcode = OP_R_TYPE; w_illegal = 1'b0; w_class = CLS_ALU; end
            CW_ADDI:            begin w_opcode = OP_ADDI;   w_illegal = 1'b0; w_class = CLS_ALU; end
            CW_ORI:             begin w_opcode = OP_ORI;    w_illegal = 1'b0; w_class = CLS_ALU; end
            CW_ANDI:            begin w_opcode = OP_ANDI;   w_illegal = 1'b0; w_class = CLS_ALU; end
            CW_LUI:             begin w_opcode = OP_LUI;    w_illegal = 1'b0; w_class = CLS_ALU; end
            CW_LW:              begin w_opcode = OP_LW;     w_illegal = 1'b0; w_class = CLS_MEM; end
            CW_SW, CW_DEFAULT:  begin w_opcode = OP_SW;     w_illegal = 1'b0; w_class = CLS_MEM; end
            CW_BEQ:             begin w_opcode = OP_BEQ;    w_illegal = 1'b0; w_class = CLS_BR;  end
            CW_BNE:             begin w_opcode = OP_BNE;    w_illegal = 1'b0; w_class = CLS_BR;  end
            CW_J:               begin w_opcode = OP_J;      w_illegal = 1'b0; w_class = CLS_JMP; end
            CW_JAL:             begin w_opcode = OP_JAL;    w_illegal = 1'b0; w_class = CLS_JMP; end
            default:            ;
        endcase
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_traceFifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (r_capValid),
        .i_pushData ({w_opcode, w_illegal, r_capPc}),
        .i_pop      (out_ready),
        .o_headData (w_head),
        .o_valid    (out_valid),
        .o_full     (fifo_full),
        .o_drop     (w_drop)
    );

    // Dropped entries are still counted; a coincident clear takes priority over any increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_cntAlu   <= '0;
            r_cntMem   <= '0;
            r_cntBr    <= '0;
            r_cntJmp   <= '0;
            r_cntIll   <= '0;
        end else if (clr_stats) begin
            r_overflow <= 1'b0;
            r_cntAlu   <= '0;
            r_cntMem   <= '0;
            r_cntBr    <= '0;
            r_cntJmp   <= '0;
            r_cntIll   <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (r_capValid) begin
                case (w_class)
                    CLS_ALU: r_cntAlu <= satInc(r_cntAlu);
                    CLS_MEM: r_cntMem <= satInc(r_cntMem);
                    CLS_BR:  r_cntBr  <= satInc(r_cntBr);
                    CLS_JMP: r_cntJmp <= satInc(r_cntJmp);
                    default: r_cntIll <= satInc(r_cntIll);
                endcase
            end
        end
    end

    assign out_opcode  = w_head[FW-1:FW-6];
    assign out_illegal = w_head[PC_W];
    assign out_pc      = w_head[PC_W-1:0];
    assign overflow    = r_overflow;
    assign cnt_alu     = r_cntAlu;
    assign cnt_mem     = r_cntMem;
    assign cnt_br      = r_cntBr;
    assign cnt_jmp     = r_cntJmp;
    assign cnt_ill     = r_cntIll;

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// Directed bench for ctrl_trace_encoder: a scoreboard checks every popped head entry, plus counter/flag checks.
module tb_ctrl_trace_encoder;

    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [11:0]      ctrl_word;
    logic [PC_W-1:0]  in_pc;
    logic             out_ready;
    logic             clr_stats;
    logic             out_valid;
    logic [5:0]       out_opcode;
    logic             out_illegal;
    logic [PC_W-1:0]  out_pc;
    logic             fifo_full;
    logic             overflow;
    logic [CNT_W-1:0] cnt_alu;
    logic [CNT_W-1:0] cnt_mem;
    logic [CNT_W-1:0] cnt_br;
    logic [CNT_W-1:0] cnt_jmp;
    logic [CNT_W-1:0] cnt_ill;

    int passCount  = 0;
    int checkCount = 0;

    logic [38:0] expQ [$];

    logic [11:0] wordTable [11] = '{12'h907, 12'h500, 12'h502, 12'h003, 12'h005, 12'h780,
                                    12'h800, 12'h014, 12'h024, 12'h00E, 12'h00C};
    logic [5:0]  opTable   [11] = '{6'h00, 6'h08, 6'h0D, 6'h0C, 6'h0F, 6'h23,
                                    6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    ctrl_trace_encoder #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .ctrl_word   (ctrl_word),
        .in_pc       (in_pc),
        .out_ready   (out_ready),
        .clr_stats   (clr_stats),
        .out_valid   (out_valid),
        .out_opcode  (out_opcode),
        .out_illegal (out_illegal),
        .out_pc      (out_pc),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .cnt_alu     (cnt_alu),
        .cnt_mem     (cnt_mem),
        .cnt_br      (cnt_br),
        .cnt_jmp     (cnt_jmp),
        .cnt_ill     (cnt_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge so they are stable at the next edge.
    task automatic applyStimulus(input logic valid, input logic [11:0] word, input logic [PC_W-1:0] pc,
                                 input logic ready, input logic clr);
        @(posedge clk);
        #1;
        in_valid  = valid;
        ctrl_word = word;
        in_pc     = pc;
        out_ready = ready;
        clr_stats = clr;
    endtask

    task automatic issueWord(input logic [11:0] word, input logic [5:0] op, input logic ill,
                             input logic [PC_W-1:0] pc, input logic ready, input logic record);
        applyStimulus(1'b1, word, pc, ready, 1'b0);
        if (record) expQ.push_back({op, ill, pc});
    endtask

    task automatic idleCycles(input int n, input logic ready);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 12'h000, '0, ready, 1'b0);
    endtask

    // Scoreboard: whatever the DUT pops must be the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("extra_entry", 64'(expQ.size()), 64'd1);
            end else begin
                checkOutput("head_entry", {25'd0, out_opcode, out_illegal, out_pc}, {25'd0, expQ.pop_front()});
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        ctrl_word = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        clr_stats = 1'b0;

        #3;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_fifo_full", fifo_full, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_opcode", out_opcode, 6'h00);
        checkOutput("rst_cnt_alu", cnt_alu, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Round trip through every legal bundle, consumer always ready.
        for (int i = 0; i < 11; i++) issueWord(wordTable[i], opTable[i], 1'b0, 32'h400 + 32'(4 * i), 1'b1, 1'b1);
        idleCycles(4, 1'b1);
        @(negedge clk);
        checkOutput("rt_cnt_alu", cnt_alu, 4'd5);
        checkOutput("rt_cnt_mem", cnt_mem, 4'd2);
        checkOutput("rt_cnt_br", cnt_br, 4'd2);
        checkOutput("rt_cnt_jmp", cnt_jmp, 4'd2);
        checkOutput("rt_cnt_ill", cnt_ill, 4'd0);
        checkOutput("rt_drained", 64'(expQ.size()), 64'd0);
        checkOutput("rt_out_valid", out_valid, 1'b0);

        // Illegal bundle and the accepted 0x000 alias.
        applyStimulus(1'b0, 12'h000, '0, 1'b1, 1'b1);
        issueWord(12'h180, 6'h3F, 1'b1, 32'h3000, 1'b1, 1'b1);
        issueWord(12'h000, 6'h2B, 1'b0, 32'h3004, 1'b1, 1'b1);
        idleCycles(4, 1'b1);
        @(negedge clk);
        checkOutput("ill_cnt_ill", cnt_ill, 4'd1);
        checkOutput("ill_cnt_mem", cnt_mem, 4'd1);
        checkOutput("ill_cnt_alu", cnt_alu, 4'd0);

        // Fill past capacity with the consumer stalled; the last two entries are dropped.
        applyStimulus(1'b0, 12'h000, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++)
            issueWord(wordTable[i], opTable[i], 1'b0, 32'h1000 + 32'(4 * i), 1'b0, i < DEPTH);
        idleCycles(2, 1'b0);
        @(negedge clk);
        checkOutput("full_flag", fifo_full, 1'b1);
        checkOutput("full_overflow", overflow, 1'b1);
        checkOutput("full_cnt_alu", cnt_alu, 4'd5);
        checkOutput("full_cnt_jmp", cnt_jmp, 4'd1);
        checkOutput("full_cnt_total", 64'(cnt_alu) + 64'(cnt_mem) + 64'(cnt_br) + 64'(cnt_jmp) + 64'(cnt_ill),
                    64'(DEPTH + 2));

        // Clearing statistics leaves the queued entries alone.
        applyStimulus(1'b0, 12'h000, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 12'h000, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("clr_overflow", overflow, 1'b0);
        checkOutput("clr_keeps_full", fifo_full, 1'b1);
        checkOutput("clr_cnt_alu", cnt_alu, 4'd0);

        // Push and pop in the same cycle while full.
        issueWord(12'h005, 6'h0F, 1'b0, 32'h2000, 1'b0, 1'b1);
        applyStimulus(1'b0, 12'h000, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 12'h000, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pp_overflow", overflow, 1'b0);
        checkOutput("pp_still_full", fifo_full, 1'b1);
        checkOutput("pp_cnt_alu", cnt_alu, 4'd1);
        idleCycles(DEPTH + 2, 1'b1);
        @(negedge clk);
        checkOutput("pp_drained", 64'(expQ.size()), 64'd0);
        checkOutput("pp_empty", out_valid, 1'b0);
        checkOutput("pp_not_full", fifo_full, 1'b0);

        // Saturation, then clear racing an increment.
        applyStimulus(1'b0, 12'h000, '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) issueWord(12'h500, 6'h08, 1'b0, 32'h5000 + 32'(4 * i), 1'b1, 1'b1);
        idleCycles(3, 1'b1);
        @(negedge clk);
        checkOutput("sat_cnt_alu", cnt_alu, 4'd15);
        issueWord(12'h500, 6'h08, 1'b0, 32'h6000, 1'b1, 1'b1);
        applyStimulus(1'b0, 12'h000, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, 12'h000, '0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("clr_wins", cnt_alu, 4'd0);
        issueWord(12'h500, 6'h08, 1'b0, 32'h6004, 1'b1, 1'b1);
        idleCycles(3, 1'b1);
        @(negedge clk);
        checkOutput("after_clr_inc", cnt_alu, 4'd1);

        // Mid-stream reset with three entries queued.
        for (int i = 0; i < 3; i++) issueWord(wordTable[i], opTable[i], 1'b0, 32'h7000 + 32'(4 * i), 1'b0, 1'b1);
        idleCycles(2, 1'b0);
        @(negedge clk);
        checkOutput("mid_queued", out_valid, 1'b1);
        #1;
        reset = 1'b0;
        expQ.delete();
        #1;
        checkOutput("mid_rst_valid", out_valid, 1'b0);
        checkOutput("mid_rst_opcode", out_opcode, 6'h00);
        checkOutput("mid_rst_pc", out_pc, 32'h0);
        checkOutput("mid_rst_cnt_alu", cnt_alu, 4'd0);
        checkOutput("mid_rst_full", fifo_full, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        idleCycles(3, 1'b0);
        @(negedge clk);
        checkOutput("post_rst_empty", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
